// File: rtl/cond_issue_ctrl.sv
// Condition-execute issue controller sitting between decode and the ALU.
// Owns the architectural NZCV flags, evaluates each instruction's ARM
// condition field, stalls on flag hazards from in-flight S instructions and
// issues every instruction to the ALU marked execute or annul.
//
// Handshakes (both ports): a transfer happens on a rising clk edge where
// valid && ready are both 1. valid never depends on ready from the same
// port; once iss_valid is raised, iss_exec/iss_s/iss_data stay stable until
// the transfer. in_ready depends only on state and iss_ready.
module cond_issue_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_cond,
  input  logic              in_s,
  input  logic [DATA_W-1:0] in_data,
  output logic              iss_valid,
  input  logic              iss_ready,
  output logic              iss_exec,
  output logic              iss_s,
  output logic [DATA_W-1:0] iss_data,
  input  logic              wb_valid,
  input  logic [3:0]        wb_nzcv,
  output logic [3:0]        nzcv,
  output logic [15:0]       squash_cnt,
  output logic              err,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_ISSUE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  held_cond;
  logic [2:0]  pend_cnt;
  logic [2:0]  pend_eff;
  logic [3:0]  pend_sum;
  logic [3:0]  pend_dec;
  logic [3:0]  eff_nzcv;
  logic        fire;
  logic        inc;
  logic        accept;
  logic        haz_in;
  logic        haz_held;

  // ARM condition-code evaluation against a given NZCV value
  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    n  = f[3];
    z  = f[2];
    cf = f[1];
    v  = f[0];
    case (c)
      4'd0:    return z;
      4'd1:    return !z;
      4'd2:    return cf;
      4'd3:    return !cf;
      4'd4:    return n;
      4'd5:    return !n;
      4'd6:    return v;
      4'd7:    return !v;
      4'd8:    return cf && !z;
      4'd9:    return !cf || z;
      4'd10:   return n == v;
      4'd11:   return n != v;
      4'd12:   return !z && (n == v);
      4'd13:   return z || (n != v);
      4'd14:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // AL and NV never look at the flags, so they never wait on them
  function automatic logic hazard_of(input logic [3:0] c, input logic s,
                                     input logic [2:0] pe);
    logic needs_flags;
    needs_flags = (c != 4'd14) && (c != 4'd15);
    return (needs_flags && (pe != 3'd0)) || (s && (pe == 3'd7));
  endfunction

  // Handshake terms, flag bypass and the effective pending-S count
  always_comb begin
    fire     = iss_valid && iss_ready;
    inc      = fire && iss_exec && iss_s;
    accept   = in_valid && in_ready;
    eff_nzcv = wb_valid ? wb_nzcv : nzcv;
    pend_sum = {1'b0, pend_cnt} + {3'd0, inc};
    if (wb_valid && (pend_sum != 4'd0)) pend_dec = pend_sum - 4'd1;
    else                                pend_dec = pend_sum;
    pend_eff = (pend_dec > 4'd7) ? 3'd7 : pend_dec[2:0];
    haz_in   = hazard_of(in_cond, in_s, pend_eff);
    haz_held = hazard_of(held_cond, iss_s, pend_eff);
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) state_nxt = haz_in ? S_WAIT : S_ISSUE;
      end
      S_WAIT: begin
        if (!haz_held) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        if (fire) begin
          if (accept) state_nxt = haz_in ? S_WAIT : S_ISSUE;
          else        state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: ready/valid decode and the debug state view
  always_comb begin
    in_ready  = 1'b0;
    iss_valid = 1'b0;
    dbg_state = state;
    case (state)
      S_IDLE:  in_ready = 1'b1;
      S_WAIT:  in_ready = 1'b0;
      S_ISSUE: begin
        in_ready  = iss_ready;
        iss_valid = 1'b1;
      end
      default: in_ready = 1'b0;
    endcase
  end

  // Holding register; the execute decision uses bypassed flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_cond <= 4'd0;
      iss_s     <= 1'b0;
      iss_data  <= '0;
      iss_exec  <= 1'b0;
    end else if (accept) begin
      held_cond <= in_cond;
      iss_s     <= in_s;
      iss_data  <= in_data;
      iss_exec  <= haz_in ? 1'b0 : cond_pass(in_cond, eff_nzcv);
    end else if ((state == S_WAIT) && !haz_held) begin
      iss_exec  <= cond_pass(held_cond, eff_nzcv);
    end
  end

  // Flags, pending-S tracking, squash counter and sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nzcv       <= 4'd0;
      pend_cnt   <= 3'd0;
      squash_cnt <= 16'd0;
      err        <= 1'b0;
    end else begin
      pend_cnt <= pend_eff;
      if (wb_valid) nzcv <= wb_nzcv;
      if (wb_valid && (pend_cnt == 3'd0) && !inc) err <= 1'b1;
      if (fire && !iss_exec && (squash_cnt != 16'hFFFF))
        squash_cnt <= squash_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_cond_issue_ctrl.sv
// Directed bench for cond_issue_ctrl: a transaction-level model of the
// controller is compared against the DUT every cycle, and each scenario
// also pins a few hand-computed literal results.
module tb_cond_issue_ctrl;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [3:0]   in_cond = 4'd0;
  logic         in_s = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         iss_ready = 1'b0;
  logic         wb_valid = 1'b0;
  logic [3:0]   wb_nzcv = 4'd0;
  logic         in_ready, iss_valid, iss_exec, iss_s, err;
  logic [W-1:0] iss_data;
  logic [3:0]   nzcv;
  logic [15:0]  squash_cnt;
  logic [1:0]   dbg_state;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  typedef struct {
    int           cyc;
    logic         exec;
    logic [W-1:0] data;
  } fire_t;
  fire_t        log_q[$];
  logic [W-1:0] exp_q[$];

  cond_issue_ctrl #(.DATA_W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_cond(in_cond),
    .in_s(in_s), .in_data(in_data),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_exec(iss_exec),
    .iss_s(iss_s), .iss_data(iss_data),
    .wb_valid(wb_valid), .wb_nzcv(wb_nzcv),
    .nzcv(nzcv), .squash_cnt(squash_cnt), .err(err), .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    check(name, {31'd0, act}, {31'd0, exp});
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic pass_f(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    case (c)
      4'd0: return z;            4'd1: return !z;
      4'd2: return cf;           4'd3: return !cf;
      4'd4: return n;            4'd5: return !n;
      4'd6: return v;            4'd7: return !v;
      4'd8: return cf && !z;     4'd9: return !cf || z;
      4'd10: return n == v;      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic must_wait(input logic [3:0] c, input logic s, input int pe);
    return ((c < 4'd14) && (pe > 0)) || (s && (pe == 7));
  endfunction

  // Model state: one instruction slot, either waiting on flags or offered
  logic         m_full = 0, m_wait = 0, m_exec = 0, m_s = 0, m_err = 0;
  logic [3:0]   m_cond = 0, m_nzcv = 0;
  logic [W-1:0] m_data = '0;
  int           m_pend = 0, m_sq = 0;

  always @(posedge clk or negedge rst_n) begin : model
    logic v, rdy, f, inc, acc;
    logic [3:0] eff;
    int pe;
    if (!rst_n) begin
      m_full = 0; m_wait = 0; m_exec = 0; m_s = 0; m_err = 0;
      m_cond = 0; m_nzcv = 0; m_data = '0; m_pend = 0; m_sq = 0;
    end else begin
      v   = m_full && !m_wait;
      rdy = !m_full || (!m_wait && iss_ready);
      f   = v && iss_ready;
      inc = f && m_exec && m_s;
      pe  = m_pend + (inc ? 1 : 0) - (wb_valid ? 1 : 0);
      if (pe < 0) pe = 0;
      if (wb_valid && (m_pend == 0) && !inc) m_err = 1;
      eff = wb_valid ? wb_nzcv : m_nzcv;
      if (f && !m_exec && (m_sq < 65535)) m_sq++;
      acc = in_valid && rdy;
      if (acc) begin
        m_full = 1; m_cond = in_cond; m_s = in_s; m_data = in_data;
        m_wait = must_wait(in_cond, in_s, pe);
        m_exec = m_wait ? 1'b0 : pass_f(in_cond, eff);
      end else if (f) begin
        m_full = 0;
      end else if (m_full && m_wait && !must_wait(m_cond, m_s, pe)) begin
        m_wait = 0;
        m_exec = pass_f(m_cond, eff);
      end
      m_pend = pe;
      if (wb_valid) m_nzcv = wb_nzcv;
    end
  end

  // scoreboard: every cycle, away from the active edge
  always @(negedge clk) begin : compare
    logic mv, mr;
    logic [W-1:0] e;
    cyc++;
    mv = m_full && !m_wait;
    mr = !m_full || (!m_wait && iss_ready);
    check1("in_ready", in_ready, mr);
    check1("iss_valid", iss_valid, mv);
    check("nzcv", {28'd0, nzcv}, {28'd0, m_nzcv});
    check("squash_cnt", {16'd0, squash_cnt}, 32'(m_sq));
    check1("err", err, m_err);
    if (mv) begin
      check1("iss_exec", iss_exec, m_exec);
      check1("iss_s", iss_s, m_s);
      check("iss_data", iss_data, m_data);
    end
    if (rst_n && iss_valid && iss_ready) begin
      log_q.push_back('{cyc: cyc, exec: iss_exec, data: iss_data});
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL fire_order: issue of %0h with no accepted instruction", iss_data);
      end else begin
        e = exp_q.pop_front();
        check("fire_order", iss_data, e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [3:0] c, input logic s, input logic [W-1:0] d);
    logic acc;
    acc = 0;
    in_valid = 1; in_cond = c; in_s = s; in_data = d;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 0;
    if (acc) exp_q.push_back(d);
    else begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: data %0h never accepted", d);
    end
  endtask

  task automatic wb_pulse(input logic [3:0] n);
    wb_valid = 1; wb_nzcv = n;
    @(posedge clk);
    #1;
    wb_valid = 0;
  endtask

  task automatic drain();
    logic done;
    done = 0;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      done = !iss_valid && in_ready;
    end
    @(posedge clk);
    #1;
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: controller never returned to idle");
    end
  endtask

  // One executed flag-setting AL instruction followed by its writeback
  task automatic s_with_wb(input logic [3:0] n, input logic [W-1:0] d);
    send(4'd14, 1'b1, d);
    @(posedge clk);
    #1;
    wb_pulse(n);
  endtask

  // ---------------- directed scenarios ----------------
  logic [3:0] ct_cond[6] = '{4'd10, 4'd11, 4'd12, 4'd4, 4'd15, 4'd7};
  logic       ct_exp[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  initial begin : main
    int base;
    repeat (3) @(posedge clk);
    #1;
    check1("rst_in_ready", in_ready, 1'b1);
    check1("rst_iss_valid", iss_valid, 1'b0);
    check("rst_nzcv", {28'd0, nzcv}, 32'd0);
    check("rst_iss_data", iss_data, 32'd0);
    rst_n = 1;
    iss_ready = 1;
    @(posedge clk);
    #1;

    // back-to-back AL instructions
    base = log_q.size();
    for (int i = 0; i < 4; i++) send(4'd14, 1'b0, 32'hA000_0000 + 32'(i));
    drain();
    check("b2b_count", 32'(log_q.size() - base), 32'd4);
    for (int i = 0; i < 4 && (base + i) < log_q.size(); i++) begin
      check1("b2b_exec", log_q[base + i].exec, 1'b1);
      check("b2b_data", log_q[base + i].data, 32'hA000_0000 + 32'(i));
      if (i > 0) check("b2b_gap", 32'(log_q[base + i].cyc - log_q[base + i - 1].cyc), 32'd1);
    end
    check("b2b_squash", {16'd0, squash_cnt}, 32'd0);

    // flag hazard: ADDS then EQ, writeback two cycles after ADDS fires
    send(4'd14, 1'b1, 32'h0000_ADD5);
    send(4'd0, 1'b0, 32'h0000_E0E0);
    check1("haz_wait_in_ready", in_ready, 1'b0);
    check1("haz_wait_valid", iss_valid, 1'b0);
    @(posedge clk);
    #1;
    check1("haz_still_wait", iss_valid, 1'b0);
    check("haz_nzcv_before", {28'd0, nzcv}, 32'd0);
    wb_pulse(4'b0100);
    check1("haz_issue_valid", iss_valid, 1'b1);
    check1("haz_issue_exec", iss_exec, 1'b1);
    check("haz_issue_data", iss_data, 32'h0000_E0E0);
    check("haz_nzcv", {28'd0, nzcv}, 32'h4);
    drain();

    // condition table with NZCV = 1001
    s_with_wb(4'b1001, 32'h0000_05E7);
    check("ct_nzcv", {28'd0, nzcv}, 32'h9);
    base = log_q.size();
    for (int i = 0; i < 6; i++) send(ct_cond[i], 1'b0, 32'h0000_00C0 + 32'(i));
    drain();
    check("ct_count", 32'(log_q.size() - base), 32'd6);
    for (int i = 0; i < 6 && (base + i) < log_q.size(); i++)
      check1("ct_exec", log_q[base + i].exec, ct_exp[i]);
    check("ct_squash", {16'd0, squash_cnt}, 32'd3);

    // backpressure with an annulled S instruction (NE while Z=1)
    s_with_wb(4'b0100, 32'h0000_0A11);
    iss_ready = 0;
    send(4'd1, 1'b1, 32'h0000_BEEF);
    for (int i = 0; i < 3; i++) begin
      check1("bp_valid", iss_valid, 1'b1);
      check1("bp_in_ready", in_ready, 1'b0);
      check1("bp_exec", iss_exec, 1'b0);
      check1("bp_s", iss_s, 1'b1);
      check("bp_data", iss_data, 32'h0000_BEEF);
      @(posedge clk);
      #1;
    end
    iss_ready = 1;
    @(posedge clk);
    #1;
    check("bp_squash", {16'd0, squash_cnt}, 32'd4);
    check("bp_nzcv", {28'd0, nzcv}, 32'h4);
    check1("bp_err_clear", err, 1'b0);

    // spurious writeback: nothing pending, so the annulled S added nothing
    wb_pulse(4'b0010);
    check1("spur_err", err, 1'b1);
    check("spur_nzcv", {28'd0, nzcv}, 32'h2);
    repeat (3) @(posedge clk);
    #1;
    check1("spur_err_sticky", err, 1'b1);

    // reset while an instruction is held in ISSUE
    iss_ready = 0;
    send(4'd14, 1'b1, 32'h0000_0055);
    #2;
    rst_n = 0;
    #1;
    check1("mid_rst_in_ready", in_ready, 1'b1);
    check1("mid_rst_valid", iss_valid, 1'b0);
    check1("mid_rst_exec", iss_exec, 1'b0);
    check1("mid_rst_s", iss_s, 1'b0);
    check("mid_rst_data", iss_data, 32'd0);
    check("mid_rst_nzcv", {28'd0, nzcv}, 32'd0);
    check("mid_rst_squash", {16'd0, squash_cnt}, 32'd0);
    check1("mid_rst_err", err, 1'b0);
    exp_q.delete();
    @(posedge clk);
    #2;
    rst_n = 1;
    @(posedge clk);
    #1;
    iss_ready = 1;
    send(4'd14, 1'b0, 32'h0000_0066);
    check1("post_rst_latency", iss_valid, 1'b1);
    check("post_rst_data", iss_data, 32'h0000_0066);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
